// File: rtl/stepper_sequencer.sv
// Command-driven unipolar stepper sequencer: runs the external delay counter handshake per step,
// advances the coil phase and tracks position. Define STEPPER_HALF_STEP_EN for the 8-entry half-step table.
module stepper_sequencer #(
    parameter int unsigned POS_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [15:0]      cmd_steps,
    input  logic [7:0]       cmd_delay,
    input  logic             abort,
    input  logic             hold_en,
    output logic             dly_start,
    output logic             dly_enable,
    output logic [7:0]       dly_delay,
    input  logic             dly_done,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             move_done,
    output logic             move_aborted,
    output logic [POS_W-1:0] position
);

    localparam int unsigned STEPS_W = 16;
    localparam int unsigned DLY_W   = 8;
    localparam int unsigned COIL_W  = 4;
`ifdef STEPPER_HALF_STEP_EN
    localparam int unsigned PH_W    = 3;
`else
    localparam int unsigned PH_W    = 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t              state, state_next;
    logic                dir_q, dir_d;
    logic [STEPS_W-1:0]  remaining, remaining_d;
    logic [PH_W-1:0]     phase, phase_d;
    logic [POS_W-1:0]    position_d;
    logic [DLY_W-1:0]    dly_delay_d;
    logic [COIL_W-1:0]   coil_d;
    logic                cmd_ready_d, busy_d, dly_start_d, dly_enable_d;
    logic                move_done_d, move_aborted_d;
    logic                accept, do_step, abort_hit;

    // Coil pattern for a phase index
    function automatic logic [COIL_W-1:0] phase_pattern(input logic [PH_W-1:0] ph);
`ifdef STEPPER_HALF_STEP_EN
        case (ph)
            3'd0:    phase_pattern = 4'b0001;
            3'd1:    phase_pattern = 4'b0011;
            3'd2:    phase_pattern = 4'b0010;
            3'd3:    phase_pattern = 4'b0110;
            3'd4:    phase_pattern = 4'b0100;
            3'd5:    phase_pattern = 4'b1100;
            3'd6:    phase_pattern = 4'b1000;
            default: phase_pattern = 4'b1001;
        endcase
`else
        case (ph)
            2'd0:    phase_pattern = 4'b0011;
            2'd1:    phase_pattern = 4'b0110;
            2'd2:    phase_pattern = 4'b1100;
            default: phase_pattern = 4'b1001;
        endcase
`endif
    endfunction

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            dir_q        <= 1'b0;
            remaining    <= '0;
            phase        <= '0;
            position     <= '0;
            dly_delay    <= '0;
            coil         <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            dly_start    <= 1'b0;
            dly_enable   <= 1'b0;
            move_done    <= 1'b0;
            move_aborted <= 1'b0;
        end else begin
            state        <= state_next;
            dir_q        <= dir_d;
            remaining    <= remaining_d;
            phase        <= phase_d;
            position     <= position_d;
            dly_delay    <= dly_delay_d;
            coil         <= coil_d;
            cmd_ready    <= cmd_ready_d;
            busy         <= busy_d;
            dly_start    <= dly_start_d;
            dly_enable   <= dly_enable_d;
            move_done    <= move_done_d;
            move_aborted <= move_aborted_d;
        end
    end

    assign abort_hit = abort && (state != S_IDLE);

    // Next-state logic; abort outside IDLE overrides everything
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_valid && (cmd_steps != '0)) state_next = S_LOAD;
            S_LOAD:  state_next = S_WAIT;
            S_WAIT:  if (dly_done) state_next = S_STEP;
            S_STEP:  state_next = (remaining == STEPS_W'(1)) ? S_DONE : S_LOAD;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort_hit) state_next = S_IDLE;
    end

    // Datapath and registered-output next values, decoded from the next state
    always_comb begin
        dir_d       = dir_q;
        remaining_d = remaining;
        phase_d     = phase;
        position_d  = position;
        dly_delay_d = dly_delay;
        accept      = (state == S_IDLE) && cmd_valid;
        do_step     = (state == S_STEP) && !abort;

        if (accept) begin
            dir_d       = cmd_dir;
            remaining_d = cmd_steps;
            dly_delay_d = cmd_delay;
        end
        if (do_step) begin
            remaining_d = remaining - STEPS_W'(1);
            phase_d     = dir_q ? phase + PH_W'(1) : phase - PH_W'(1);
            position_d  = dir_q ? position + POS_W'(1) : position - POS_W'(1);
        end
        if (abort_hit) remaining_d = '0;

        cmd_ready_d    = (state_next == S_IDLE);
        busy_d         = (state_next != S_IDLE);
        dly_start_d    = (state_next == S_LOAD);
        dly_enable_d   = (state_next == S_WAIT);
        move_done_d    = (state_next == S_DONE) || (accept && (cmd_steps == '0));
        move_aborted_d = abort_hit;
        coil_d         = ((state_next != S_IDLE) || hold_en) ? phase_pattern(phase_d) : '0;
    end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Self-checking bench for stepper_sequencer: delay-counter model plus a per-step scoreboard of coil/position.
module tb_stepper_sequencer;

    localparam int unsigned POS_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [15:0]      cmd_steps;
    logic [7:0]       cmd_delay;
    logic             abort;
    logic             hold_en;
    logic             dly_start;
    logic             dly_enable;
    logic [7:0]       dly_delay;
    logic             dly_done;
    logic [3:0]       coil;
    logic             busy;
    logic             move_done;
    logic             move_aborted;
    logic [POS_W-1:0] position;

    typedef struct packed {
        logic [3:0]  coil;
        logic [15:0] pos;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          phase_m;
    logic [15:0] pos_m;
    int          dcnt;

    stepper_sequencer #(.POS_W(POS_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .cmd_steps    (cmd_steps),
        .cmd_delay    (cmd_delay),
        .abort        (abort),
        .hold_en      (hold_en),
        .dly_start    (dly_start),
        .dly_enable   (dly_enable),
        .dly_delay    (dly_delay),
        .dly_done     (dly_done),
        .coil         (coil),
        .busy         (busy),
        .move_done    (move_done),
        .move_aborted (move_aborted),
        .position     (position)
    );

    always #5 clk = ~clk;

    // Delay counter model: done rises 4 cycles after a start strobe, cleared by the next start
    always @(posedge clk) begin
        if (!reset_n) begin
            dcnt     <= 0;
            dly_done <= 1'b0;
        end else if (dly_start) begin
            dcnt     <= 4;
            dly_done <= 1'b0;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) dly_done <= 1'b1;
        end
    end

    function automatic logic [3:0] pattern_m(input int ph);
`ifdef STEPPER_HALF_STEP_EN
        case (ph)
            0: return 4'b0001;
            1: return 4'b0011;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0100;
            5: return 4'b1100;
            6: return 4'b1000;
            default: return 4'b1001;
        endcase
`else
        case (ph)
            0: return 4'b0011;
            1: return 4'b0110;
            2: return 4'b1100;
            default: return 4'b1001;
        endcase
`endif
    endfunction

`ifdef STEPPER_HALF_STEP_EN
    localparam int PH_N = 8;
`else
    localparam int PH_N = 4;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset(input bit chk);
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
        if (chk) begin
            check("rst_coil", 32'(coil), 32'h0);
            check("rst_position", 32'(position), 32'h0);
            check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_dly_start", 32'(dly_start), 32'h0);
            check("rst_dly_enable", 32'(dly_enable), 32'h0);
            check("rst_move_done", 32'(move_done), 32'h0);
            check("rst_move_aborted", 32'(move_aborted), 32'h0);
            check("rst_dly_delay", 32'(dly_delay), 32'h0);
        end
        reset_n = 1'b1;
        phase_m = 0;
        pos_m   = '0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Issue one move; abort_at>0 aborts in WAIT of that step; busy_cmd keeps a conflicting command asserted
    task automatic run_move(input logic dir, input logic [15:0] steps, input logic [7:0] dly,
                            input int abort_at, input bit busy_cmd);
        int          starts;
        int          n_exp;
        bit          finished;
        logic [15:0] last_pos;
        exp_t        e;
        starts   = 0;
        finished = 0;
        n_exp    = (abort_at > 0) ? abort_at - 1 : int'(steps);
        for (int i = 0; i < n_exp; i++) begin
            phase_m = dir ? (phase_m + 1) % PH_N : (phase_m + PH_N - 1) % PH_N;
            pos_m   = dir ? pos_m + 16'd1 : pos_m - 16'd1;
            e.coil  = pattern_m(phase_m);
            e.pos   = pos_m;
            exp_q.push_back(e);
        end
        last_pos  = position;
        cmd_dir   = dir;
        cmd_steps = steps;
        cmd_delay = dly;
        cmd_valid = 1'b1;
        @(negedge clk);
        if (busy_cmd) begin
            cmd_dir   = ~dir;
            cmd_steps = 16'd7;
            cmd_delay = 8'd99;
        end else begin
            cmd_valid = 1'b0;
        end
        for (int c = 0; c < 2000 && !finished; c++) begin
            if (dly_start) begin
                starts++;
                check("dly_delay", 32'(dly_delay), 32'(dly));
            end
            check("start_enable_overlap", 32'(dly_start & dly_enable), 32'h0);
            check("ready_in_move", 32'(cmd_ready), 32'h0);
            check("busy_in_move", 32'(busy), 32'h1);
            if (position != last_pos) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_step", 32'(position), 32'(last_pos));
                end else begin
                    e = exp_q.pop_front();
                    check("step_coil", 32'(coil), 32'(e.coil));
                    check("step_position", 32'(position), 32'(e.pos));
                end
                last_pos = position;
            end
            if (move_done) begin
                cmd_valid = 1'b0;
                check("done_not_aborted", 32'(move_aborted), 32'h0);
                check("done_expected", 32'(abort_at), 32'h0);
                @(negedge clk);
                check("done_pulse_width", 32'(move_done), 32'h0);
                check("ready_after_done", 32'(cmd_ready), 32'h1);
                check("busy_after_done", 32'(busy), 32'h0);
                finished = 1;
            end else if (abort_at > 0 && starts == abort_at && dly_enable) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_busy", 32'(busy), 32'h0);
                check("abort_ready", 32'(cmd_ready), 32'h1);
                check("abort_pulse", 32'(move_aborted), 32'h1);
                check("abort_no_done", 32'(move_done), 32'h0);
                @(negedge clk);
                check("abort_pulse_width", 32'(move_aborted), 32'h0);
                check("abort_no_done_later", 32'(move_done), 32'h0);
                finished = 1;
            end else begin
                @(negedge clk);
            end
        end
        check("move_timeout", 32'(finished), 32'h1);
        check("steps_left_in_queue", 32'(exp_q.size()), 32'h0);
        check("dly_start_count", 32'(starts), (abort_at > 0) ? 32'(abort_at) : 32'(steps));
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        cmd_delay = '0;
        abort     = 1'b0;
        hold_en   = 1'b1;

        do_reset(1);

        // Forward 5 steps with a conflicting command held throughout
        run_move(1'b1, 16'd5, 8'd3, 0, 1);
        check("fwd_position", 32'(position), 32'h5);
        check("fwd_hold_coil", 32'(coil), 32'(pattern_m(phase_m)));

        // Reverse wrap from phase 0
        do_reset(0);
        run_move(1'b0, 16'd2, 8'd3, 0, 0);
        check("rev_position", 32'(position), 32'hFFFE);
        check("rev_coil", 32'(coil), 32'(pattern_m(phase_m)));

        // Abort in WAIT of step 3 of 10, holding coils
        do_reset(0);
        hold_en = 1'b1;
        run_move(1'b1, 16'd10, 8'd3, 3, 0);
        check("abort_hold_position", 32'(position), 32'h2);
        check("abort_hold_coil", 32'(coil), 32'(pattern_m(phase_m)));

        // Same abort with coils released
        do_reset(0);
        hold_en = 1'b0;
        run_move(1'b1, 16'd10, 8'd3, 3, 0);
        check("abort_free_position", 32'(position), 32'h2);
        check("abort_free_coil", 32'(coil), 32'h0);

        // Abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_ignored", 32'(move_aborted), 32'h0);

        // Zero-step command
        hold_en   = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd0;
        cmd_delay = 8'd5;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("zero_done_pulse", 32'(move_done), 32'h1);
        check("zero_busy", 32'(busy), 32'h0);
        check("zero_no_start", 32'(dly_start), 32'h0);
        check("zero_ready", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        check("zero_done_width", 32'(move_done), 32'h0);
        check("zero_no_start_later", 32'(dly_start), 32'h0);
        check("zero_busy_later", 32'(busy), 32'h0);
        check("zero_position", 32'(position), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
